// File: rtl/decrementer_bank.sv
// decrementer_bank: CHANNELS independent WIDTH-bit synchronous down-counters.
// Each channel has a parallel load, a per-channel enable gated by a shared
// ent, a combinational ripple-carry-out and a registered terminal-count pulse.
// Behaviour at zero is either saturate or wrap, selected by SATURATE.
// Optional feature macro: DECREMENTER_BANK_AUTO_RELOAD_EN. When it is defined,
// each channel gets a reload register. Counting at zero then reloads from that
// register, which overrides SATURATE.
module decrementer_bank #(
    parameter int WIDTH       = 4,
    parameter int CHANNELS    = 2,
    parameter int RESET_VALUE = 3,
    parameter int SATURATE    = 1
) (
    input  logic                      clock,
    input  logic                      clr,
    input  logic [CHANNELS-1:0]       ld,
    input  logic                      ent,
    input  logic [CHANNELS-1:0]       enp,
    input  logic [CHANNELS*WIDTH-1:0] D,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS-1:0]       rco,
    output logic [CHANNELS-1:0]       tc
);

    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] q_q, q_d;
        logic             tc_q, tc_d;
        logic             count_en;
        logic [WIDTH-1:0] d_ch;

        assign count_en = ent & enp[g];
        assign d_ch     = D[g*WIDTH +: WIDTH];

`ifdef DECREMENTER_BANK_AUTO_RELOAD_EN
        logic [WIDTH-1:0] reload_q, reload_d;

        // Next-state: load beats count; at zero the reload value is restored.
        always_comb begin
            q_d      = q_q;
            tc_d     = 1'b0;
            reload_d = reload_q;
            if (ld[g]) begin
                q_d      = d_ch;
                reload_d = d_ch;
            end else if (count_en) begin
                if (q_q != '0) begin
                    q_d  = q_q - ONE_V;
                    tc_d = (q_q == ONE_V);
                end else begin
                    q_d = reload_q;
                end
            end
        end

        // State registers with synchronous active-low clear.
        always_ff @(posedge clock) begin
            if (!clr) begin
                q_q      <= RST_V;
                tc_q     <= 1'b0;
                reload_q <= RST_V;
            end else begin
                q_q      <= q_d;
                tc_q     <= tc_d;
                reload_q <= reload_d;
            end
        end
`else
        // Next-state: load beats count; at zero either hold or wrap to all ones.
        always_comb begin
            q_d  = q_q;
            tc_d = 1'b0;
            if (ld[g]) begin
                q_d = d_ch;
            end else if (count_en) begin
                if (q_q != '0) begin
                    q_d  = q_q - ONE_V;
                    tc_d = (q_q == ONE_V);
                end else if (SATURATE != 0) begin
                    q_d = '0;
                end else begin
                    q_d = '1;
                end
            end
        end

        // State registers with synchronous active-low clear.
        always_ff @(posedge clock) begin
            if (!clr) begin
                q_q  <= RST_V;
                tc_q <= 1'b0;
            end else begin
                q_q  <= q_d;
                tc_q <= tc_d;
            end
        end
`endif

        assign Q[g*WIDTH +: WIDTH] = q_q;
        assign rco[g]              = ent & (q_q == '0);
        assign tc[g]               = tc_q;
    end

endmodule

// File: tb/tb_decrementer_bank.sv
// Directed bench for decrementer_bank: a default instance (saturating) and a
// wrapping instance (SATURATE=0). Expected values are hand-computed.
module tb_decrementer_bank;

    logic       clock;
    logic       clr;
    logic       ent;
    logic [1:0] ld,  enp;
    logic [7:0] D,   Q;
    logic [1:0] rco, tc;
    logic [1:0] w_ld, w_enp;
    logic [7:0] w_D, w_Q;
    logic [1:0] w_rco, w_tc;

    int n_checks = 0;
    int n_fail   = 0;

    decrementer_bank dut (
        .clock(clock), .clr(clr), .ld(ld), .ent(ent), .enp(enp),
        .D(D), .Q(Q), .rco(rco), .tc(tc)
    );

    decrementer_bank #(.WIDTH(4), .CHANNELS(2), .RESET_VALUE(3), .SATURATE(0)) dut_wrap (
        .clock(clock), .clr(clr), .ld(w_ld), .ent(ent), .enp(w_enp),
        .D(w_D), .Q(w_Q), .rco(w_rco), .tc(w_tc)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle before checking or driving.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clr = 1'b0; ent = 1'b0; ld = '0; enp = '0; D = '0;
        w_ld = '0; w_enp = '0; w_D = '0;

        // Reset
        step();
        chk("reset_q", Q, 8'h33);
        chk("reset_tc", tc, 2'b00);
        chk("reset_rco", rco, 2'b00);
        chk("reset_wrap_q", w_Q, 8'h33);
        ent = 1'b1;
        #1;
        chk("reset_rco_ent", rco, 2'b00);

        // Saturating count on channel 0
        clr = 1'b1; enp = 2'b01;
        step();
        chk("sat_q_e1", Q, 8'h32);
        chk("sat_tc_e1", tc, 2'b00);
        step();
        chk("sat_q_e2", Q, 8'h31);
        chk("sat_tc_e2", tc, 2'b00);
        step();
        chk("sat_q_e3", Q, 8'h30);
        chk("sat_rco_e3", rco, 2'b01);
        chk("sat_tc_e3", tc, 2'b01);
`ifndef DECREMENTER_BANK_AUTO_RELOAD_EN
        for (int k = 0; k < 5; k++) begin
            step();
            chk("sat_hold_q", Q, 8'h30);
            chk("sat_hold_tc", tc, 2'b00);
        end
`else
        step();
        chk("reload_rst_q", Q, 8'h33);
        chk("reload_rst_tc", tc, 2'b00);
`endif

        // Load priority: reload Q0=3, then load ch1 while both count
        ld = 2'b01; D = 8'h03; enp = 2'b00;
        step();
        chk("ld_q", Q, 8'h33);
        chk("ld_tc", tc, 2'b00);
        ld = 2'b10; D = 8'h9F; enp = 2'b11;
        step();
        chk("ldpri_q", Q, 8'h92);
        chk("ldpri_tc", tc, 2'b00);
        ld = 2'b00;
        step();
        chk("both_q1", Q, 8'h81);
        step();
        chk("both_q2", Q, 8'h70);
        chk("both_tc2", tc, 2'b01);
        chk("both_rco2", rco, 2'b01);

        // ent gates counting and rco combinationally
        ent = 1'b0;
        #1;
        chk("ent_off_rco", rco, 2'b00);
        step();
        chk("ent_off_q", Q, 8'h70);
        chk("ent_off_tc", tc, 2'b00);
        ent = 1'b1;
        #1;
        chk("ent_on_rco", rco, 2'b01);

        // Load to zero never pulses tc
        ld = 2'b01; D = 8'h00; enp = 2'b00;
        step();
        ld = 2'b01; D = 8'h00;
        step();
        chk("ld0_q", Q, 8'h70);
        chk("ld0_tc", tc, 2'b00);
        ld = 2'b00;

        // Clear cancels a pending tc
        ld = 2'b01; D = 8'h01;
        step();
        ld = 2'b00; enp = 2'b01;
        step();
        chk("pend_tc", tc, 2'b01);
        clr = 1'b0;
        step();
        chk("clr_pend_q", Q, 8'h33);
        chk("clr_pend_tc", tc, 2'b00);
        clr = 1'b1; enp = 2'b00;

        // Reset mid-operation overrides load and count
        ld = 2'b01; D = 8'h01;
        step();
        chk("mid_pre_q", Q, 8'h31);
        ld = 2'b01; D = 8'h07; enp = 2'b01; clr = 1'b0;
        step();
        chk("mid_q", Q, 8'h33);
        chk("mid_tc", tc, 2'b00);
        clr = 1'b1; ld = 2'b00; enp = 2'b00;
        step();
        chk("mid_after_q", Q, 8'h33);
        chk("mid_after_tc", tc, 2'b00);

`ifndef DECREMENTER_BANK_AUTO_RELOAD_EN
        // Wrap instance: Q0=0 wraps to 15, then counts back to 0 with a tc
        w_ld = 2'b01; w_D = 8'h00;
        step();
        chk("wrap_ld_q", w_Q, 8'h30);
        w_ld = 2'b00; w_enp = 2'b01;
        step();
        chk("wrap_q", w_Q, 8'h3F);
        chk("wrap_tc", w_tc, 2'b00);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("wrap_cnt_q", w_Q, {4'h3, 4'(15 - k)});
            chk("wrap_cnt_tc", w_tc, (k == 15) ? 2'b01 : 2'b00);
        end
        step();
        chk("wrap_again_q", w_Q, 8'h3F);
        chk("wrap_again_tc", w_tc, 2'b00);
        w_enp = 2'b00;
`else
        // Auto-reload: load 2 then count continuously -> 2,1,0,2,1,0
        ld = 2'b01; D = 8'h02;
        step();
        chk("ar_ld_q", Q, 8'h32);
        ld = 2'b00; enp = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("ar_q", Q, {4'h3, 4'((2 - (k % 3) + 3) % 3)});
            chk("ar_tc", tc, ((k % 3) == 2) ? 2'b01 : 2'b00);
        end
        enp = 2'b00;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
